// File: rtl/data_select_unit_pkg.sv
// Shared constants for the data select unit: operation codes and default width.
package data_select_unit_pkg;

    localparam int DEF_DW = 8;

    // Operation codes carried on the 2-bit select input.
    typedef enum logic [1:0] {
        SEL_A   = 2'd0,
        SEL_B   = 2'd1,
        SEL_ADD = 2'd2,
        SEL_SUB = 2'd3
    } sel_e;

endpackage

// File: rtl/data_select_unit_if.sv
// Operand/result bus of the data select unit. No handshake: one op per cycle.
interface data_select_unit_if
    import data_select_unit_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic        [1:0]    select;
    logic signed [DW:0]   c;

    modport master (output a, output b, output select, input  c);
    modport slave  (input  a, input  b, input  select, output c);
endinterface

// File: rtl/data_select_alu.sv
// Combinational select/add/sub on sign-extended operands; DW+1 bit result
// is wide enough that neither the sum nor the difference can overflow.
module data_select_alu
    import data_select_unit_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    input  logic        [1:0]    select,
    output logic signed [DW:0]   res
);
    logic signed [DW:0] a_ext;
    logic signed [DW:0] b_ext;

    assign a_ext = {a[DW-1], a};
    assign b_ext = {b[DW-1], b};

    // Pick the operation; all four codes are covered, default only avoids a latch.
    always_comb begin
        res = '0;
        case (sel_e'(select))
            SEL_A:   res = a_ext;
            SEL_B:   res = b_ext;
            SEL_ADD: res = a_ext + b_ext;
            SEL_SUB: res = a_ext - b_ext;
            default: res = '0;
        endcase
    end
endmodule

// File: rtl/data_select_unit.sv
// Top: output register with async clear around the combinational ALU.
module data_select_unit
    import data_select_unit_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    data_select_unit_if.slave     bus
);
    logic signed [DW:0] alu_res;

    data_select_alu #(.DW(DW)) u_alu (
        .a      (bus.a),
        .b      (bus.b),
        .select (bus.select),
        .res    (alu_res)
    );

    // Register the result every cycle; reset clears it without waiting for clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.c <= '0;
        else     bus.c <= alu_res;
    end
endmodule

// File: tb/tb_data_select_unit.sv
// Self-checking bench for data_select_unit: directed cases then random ops
// checked against an integer-arithmetic reference model.
module tb_data_select_unit;
    import data_select_unit_pkg::*;

    localparam int DW = DEF_DW;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    data_select_unit_if #(.DW(DW)) bus ();

    data_select_unit #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: operands are two's-complement DW-bit values, result is exact integer math.
    function automatic int model(input logic [DW-1:0] a, input logic [DW-1:0] b, input int s);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        case (s)
            0:       return ai;
            1:       return bi;
            2:       return ai + bi;
            default: return ai - bi;
        endcase
    endfunction

    function automatic int c_now();
        return int'(bus.c);
    endfunction

    // Drive at the falling edge, check just after the next rising edge.
    task automatic step(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b, input int s);
        @(negedge clk);
        bus.a      = a;
        bus.b      = b;
        bus.select = 2'(s);
        @(posedge clk);
        #1;
        chk(tag, c_now(), model(a, b, s));
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        int            rs;
        int            held;
        n_cmp = 0;
        n_bad = 0;

        // Reset held from time 0.
        rst        = 1'b1;
        bus.a      = 8'(-20);
        bus.b      = 8'd30;
        bus.select = 2'd0;
        #1;
        chk("reset_t0", c_now(), 0);
        @(posedge clk); #1;
        chk("reset_edge1", c_now(), 0);
        @(posedge clk); #1;
        chk("reset_edge2", c_now(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_after_reset", c_now(), -20);

        // Select sweep.
        step("sel_b",   8'(-20), 8'd30, 1);
        chk("sel_b_val", c_now(), 30);
        step("sel_add", 8'(-20), 8'd30, 2);
        chk("sel_add_val", c_now(), 10);
        step("sel_sub", 8'(-20), 8'd30, 3);
        chk("sel_sub_val", c_now(), -50);

        // Operand swap and all-ones operands.
        step("swap_sub", 8'd20, 8'(-30), 3);
        chk("swap_sub_val", c_now(), 50);
        step("ff_sub", 8'hFF, 8'hFF, 3);
        chk("ff_sub_val", c_now(), 0);
        step("ff_add", 8'hFF, 8'hFF, 2);
        chk("ff_add_val", c_now(), -2);

        // Extremes.
        step("min_add", 8'h80, 8'h80, 2);
        chk("min_add_val", c_now(), -256);
        step("min_sub_max", 8'h80, 8'h7F, 3);
        chk("min_sub_max_val", c_now(), -255);
        step("max_sub_min", 8'h7F, 8'h80, 3);
        chk("max_sub_min_val", c_now(), 255);

        // Async reset pulse between edges while c is nonzero.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clear", c_now(), 0);
        @(posedge clk); #1;
        chk("async_hold", c_now(), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("async_release", c_now(), 0);
        @(posedge clk); #1;
        chk("after_async", c_now(), 255);

        // Mid-cycle operand change must not reach c before the next edge.
        step("timing_load", 8'd5, 8'd0, 0);
        held = c_now();
        #2;
        bus.a = 8'd9;
        #1;
        chk("timing_hold", c_now(), held);
        @(posedge clk); #1;
        chk("timing_next", c_now(), 9);

        // Random ops.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = int'($urandom_range(0, 3));
            step("rand", ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
